core_seq_ctrl: RTL and testbench

- Central multi-cycle sequencer for the single-issue core.
- Replaces the ad-hoc fetch gating and PC-update handshake logic in the top level.
- Owns the architectural PC and steps the core through each instruction in order: IFU → IDU → EXU/LSU → commit.
- Stops the core on ebreak, bus error or stage timeout, and reports a halt cause to the simulation harness.

---
 rtl/core_seq_ctrl_pkg.sv | 30 +++
 rtl/core_seq_watchdog.sv | 45 ++++
 rtl/core_seq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_seq_ctrl_pkg.sv
// core_seq_ctrl_pkg
//   Shared definitions for the core sequencer: state encodings, halt-cause
//   codes, the ebreak instruction word and default parameter values.
//   Imported by core_seq_ctrl and core_seq_watchdog.
//   Optional feature macro used by the top level: CORE_SEQ_PERF_CNT_EN.
package core_seq_ctrl_pkg;

  // Encodings are visible on state_out, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_COMMIT = 3'd4,
    ST_HALT   = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    CAUSE_EBREAK    = 2'd0,
    CAUSE_FETCH_ERR = 2'd1,
    CAUSE_LSU_ERR   = 2'd2,
    CAUSE_TIMEOUT   = 2'd3
  } halt_cause_e;

  localparam logic [31:0] EBREAK_INST            = 32'h0010_0073;
  localparam logic [31:0] RESET_PC_DEFAULT       = 32'h3000_0000;
  localparam int          TIMEOUT_CYCLES_DEFAULT = 4096;
  localparam int          WDT_W_DEFAULT          = 16;

endpackage

// File: rtl/core_seq_watchdog.sv
// core_seq_watchdog
//   Per-stage cycle counter. Counts while enable is high, clears on clear
//   (any sequencer state change) and saturates at all-ones instead of
//   wrapping. expired is high during the TIMEOUT_CYCLES-th consecutive
//   enabled cycle of a stage, so a stage that has not completed by the end of
//   that cycle is stopped exactly TIMEOUT_CYCLES cycles after it was entered.
//   TIMEOUT_CYCLES = 0 disables expiry. Requires TIMEOUT_CYCLES < 2**WDT_W.
//
// Ports:
//   clock   in   core clock
//   reset   in   synchronous, active-high
//   clear   in   restart counting from zero
//   enable  in   count this cycle
//   expired out  stage time budget used up in this cycle
module core_seq_watchdog
  import core_seq_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int WDT_W          = WDT_W_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Count value seen during the last allowed cycle of a stage.
  localparam logic [WDT_W-1:0] LIMIT =
    (TIMEOUT_CYCLES > 0) ? WDT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [WDT_W-1:0] SAT   = '1;

  logic [WDT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != SAT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (TIMEOUT_CYCLES > 0) && enable && (count >= LIMIT);

endmodule

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl
//   Multi-cycle sequencer for the single-issue core. Owns the architectural
//   PC and walks each instruction through IDLE -> FETCH -> DECODE -> EXEC ->
//   COMMIT -> FETCH ... Stops in HALT (sticky until reset) on ebreak commit,
//   fetch error, LSU error or stage timeout.
//
// Handshakes: ifu_fire, idu_fire and pc_valid are single-cycle completion
//   events; each is acted on only in its own state (FETCH, DECODE, EXEC
//   respectively) and ignored anywhere else. pc_ready is high for every EXEC
//   cycle, so a commit is accepted in the cycle pc_valid && pc_ready. COMMIT
//   always holds pc_ready low for one cycle between instructions.
//
// Ports:
//   clock, reset           core clock, synchronous active-high reset
//   ifu_start  out         one-cycle pulse on FETCH entry
//   ifu_pc     out [31:0]  architectural PC
//   ifu_fire, ifu_err in   fetch done / fetch error (err qualified by fire)
//   idu_fire, idu_is_ebreak in  decode done / decoded ebreak
//   pc_valid, next_pc in   EXU commit request and next PC
//   pc_ready   out         commit accepted while high
//   lsu_err    in          LSU bus error (EXEC only)
//   a0         in  [31:0]  x10, captured as exit code at ebreak commit
//   halt, halt_cause, exit_code out  halt status for the harness
//   state_out  out [2:0]   current state encoding
//   perf_cycle/perf_instret/perf_memstall out  only with CORE_SEQ_PERF_CNT_EN
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
  parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int          WDT_W          = WDT_W_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic        ifu_start,
  output logic [31:0] ifu_pc,
  input  logic        ifu_fire,
  input  logic        ifu_err,
  input  logic        idu_fire,
  input  logic        idu_is_ebreak,
  input  logic        pc_valid,
  input  logic [31:0] next_pc,
  output logic        pc_ready,
  input  logic        lsu_err,
  input  logic [31:0] a0,
  output logic        halt,
  output logic [1:0]  halt_cause,
  output logic [31:0] exit_code,
  output logic [2:0]  state_out
`ifdef CORE_SEQ_PERF_CNT_EN
  ,
  output logic [63:0] perf_cycle,
  output logic [63:0] perf_instret,
  output logic [31:0] perf_memstall
`endif
);

  seq_state_e  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        pend_ebreak, pend_ebreak_nxt;
  halt_cause_e cause_q, cause_nxt;
  logic [31:0] exit_q, exit_nxt;
  logic        wdt_expired;
  logic        wdt_enable;
  logic        wdt_clear;

  assign wdt_enable = (state == ST_FETCH) || (state == ST_DECODE) ||
                      (state == ST_EXEC);
  assign wdt_clear  = (state_nxt != state);

  core_seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .WDT_W          (WDT_W)
  ) u_wdt (
    .clock   (clock),
    .reset   (reset),
    .clear   (wdt_clear),
    .enable  (wdt_enable),
    .expired (wdt_expired)
  );

  // Next-state logic. Within a stage the completing event always beats the
  // watchdog; in EXEC an LSU error beats a same-cycle commit.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    pend_ebreak_nxt = pend_ebreak;
    cause_nxt       = cause_q;
    exit_nxt        = exit_q;
    case (state)
      ST_IDLE: begin
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (ifu_fire) begin
          if (ifu_err) begin
            state_nxt = ST_HALT;
            cause_nxt = CAUSE_FETCH_ERR;
          end else begin
            state_nxt = ST_DECODE;
          end
        end else if (wdt_expired) begin
          state_nxt = ST_HALT;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (idu_fire) begin
          state_nxt       = ST_EXEC;
          pend_ebreak_nxt = idu_is_ebreak;
        end else if (wdt_expired) begin
          state_nxt = ST_HALT;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      ST_EXEC: begin
        if (lsu_err) begin
          state_nxt = ST_HALT;
          cause_nxt = CAUSE_LSU_ERR;
        end else if (pc_valid) begin
          if (pend_ebreak) begin
            // pc keeps the ebreak address for the harness.
            state_nxt = ST_HALT;
            cause_nxt = CAUSE_EBREAK;
            exit_nxt  = a0;
          end else begin
            state_nxt = ST_COMMIT;
            pc_nxt    = next_pc;
          end
        end else if (wdt_expired) begin
          state_nxt = ST_HALT;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      ST_COMMIT: begin
        state_nxt = ST_FETCH;
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      ifu_start   <= 1'b0;
      pend_ebreak <= 1'b0;
      cause_q     <= CAUSE_EBREAK;
      exit_q      <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      // Registered pulse: high only in the first cycle of a FETCH visit.
      ifu_start   <= (state_nxt == ST_FETCH) && (state != ST_FETCH);
      pend_ebreak <= pend_ebreak_nxt;
      cause_q     <= cause_nxt;
      exit_q      <= exit_nxt;
    end
  end

  assign ifu_pc     = pc;
  assign pc_ready   = (state == ST_EXEC);
  assign halt       = (state == ST_HALT);
  assign halt_cause = cause_q;
  assign exit_code  = exit_q;
  assign state_out  = state;

`ifdef CORE_SEQ_PERF_CNT_EN
  // An accepted commit includes the ebreak commit but not one killed by lsu_err.
  logic commit_accept;
  assign commit_accept = (state == ST_EXEC) && pc_valid && !lsu_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_cycle    <= '0;
      perf_instret  <= '0;
      perf_memstall <= '0;
    end else begin
      if ((state != ST_IDLE) && (state != ST_HALT)) begin
        perf_cycle <= perf_cycle + 64'd1;
      end
      if (commit_accept) begin
        perf_instret <= perf_instret + 64'd1;
      end
      if ((state == ST_EXEC) && !pc_valid) begin
        perf_memstall <= perf_memstall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
`timescale 1ns/1ps
// tb_core_seq_ctrl
//   Table vectors, hand-written reset sequences and random instruction
//   streams for core_seq_ctrl, built with TIMEOUT_CYCLES = 16. Inputs change
//   and outputs are sampled on the falling clock edge.
module tb_core_seq_ctrl;

  localparam int          T      = 16;
  localparam logic [31:0] RST_PC = 32'h3000_0000;
  localparam logic [2:0]  S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                          S_EXEC = 3'd3, S_COMMIT = 3'd4, S_HALT = 3'd5;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        ifu_start, ifu_fire, ifu_err, idu_fire, idu_is_ebreak;
  logic        pc_valid, pc_ready, lsu_err, halt;
  logic [31:0] ifu_pc, next_pc, a0, exit_code;
  logic [1:0]  halt_cause;
  logic [2:0]  state_out;
`ifdef CORE_SEQ_PERF_CNT_EN
  logic [63:0] perf_cycle, perf_instret;
  logic [31:0] perf_memstall;
`endif

  core_seq_ctrl #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(T), .WDT_W(16)) dut (
    .clock(clock), .reset(reset), .ifu_start(ifu_start), .ifu_pc(ifu_pc),
    .ifu_fire(ifu_fire), .ifu_err(ifu_err), .idu_fire(idu_fire),
    .idu_is_ebreak(idu_is_ebreak), .pc_valid(pc_valid), .next_pc(next_pc),
    .pc_ready(pc_ready), .lsu_err(lsu_err), .a0(a0), .halt(halt),
    .halt_cause(halt_cause), .exit_code(exit_code), .state_out(state_out)
`ifdef CORE_SEQ_PERF_CNT_EN
    , .perf_cycle(perf_cycle), .perf_instret(perf_instret),
    .perf_memstall(perf_memstall)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];   // expected ifu_pc at each FETCH entry

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction records and reference model ----------------
  // fw/dw/ew: idle cycles before the stage's completing event.
  typedef struct {
    int          fw, dw, ew;
    logic        ifu_err, ebreak, lsu_err;
    logic [31:0] npc, a0;
  } ins_t;

  typedef struct {
    logic        halted;
    logic [1:0]  cause;
    logic [31:0] exit_code;
    logic [31:0] pc;
    int          cycles, instret, memstall;
  } res_t;

  typedef struct {
    ins_t        ins;
    logic        exp_halt;
    logic [1:0]  exp_cause;
    logic [31:0] exp_pc;
    logic [31:0] exp_exit;
  } vec_t;

  ins_t prog[$];
  logic noise_en = 1'b0;

  function automatic ins_t mk(input int fw, dw, ew, input logic fe, eb, le,
                              input logic [31:0] npc, av);
    ins_t i;
    i.fw = fw; i.dw = dw; i.ew = ew;
    i.ifu_err = fe; i.ebreak = eb; i.lsu_err = le; i.npc = npc; i.a0 = av;
    return i;
  endfunction

  // Stage time budget: a stage lasts wait+1 cycles unless that exceeds T.
  function automatic int stage_len(input int w);
    return (w >= T) ? T : w + 1;
  endfunction

  // Walks the program by the architectural rules; fills exp_q with fetch PCs.
  function automatic res_t model_run();
    res_t r;
    logic [31:0] pc;
    r.halted = 1'b0; r.cause = 2'd0; r.exit_code = 32'h0; r.pc = RST_PC;
    r.cycles = 0; r.instret = 0; r.memstall = 0;
    pc = RST_PC;
    exp_q.delete();
    for (int i = 0; i < prog.size() && !r.halted; i++) begin
      exp_q.push_back(pc);
      r.cycles += stage_len(prog[i].fw);
      if (prog[i].fw >= T) begin
        r.halted = 1'b1; r.cause = 2'd3;
      end else if (prog[i].ifu_err) begin
        r.halted = 1'b1; r.cause = 2'd1;
      end else begin
        r.cycles += stage_len(prog[i].dw);
        if (prog[i].dw >= T) begin
          r.halted = 1'b1; r.cause = 2'd3;
        end else begin
          r.cycles   += stage_len(prog[i].ew);
          r.memstall += (prog[i].ew >= T) ? T : prog[i].ew;
          if (prog[i].ew >= T) begin
            r.halted = 1'b1; r.cause = 2'd3;
          end else if (prog[i].lsu_err) begin
            r.halted = 1'b1; r.cause = 2'd2;
          end else begin
            r.instret++;
            if (prog[i].ebreak) begin
              r.halted = 1'b1; r.cause = 2'd0; r.exit_code = prog[i].a0;
            end else begin
              pc = prog[i].npc;
              r.cycles++;   // COMMIT
            end
          end
        end
      end
    end
    r.pc = pc;
    if (!r.halted) exp_q.push_back(pc);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    ifu_fire = 0; ifu_err = 0; idu_fire = 0; idu_is_ebreak = 0;
    pc_valid = 0; next_pc = 0; lsu_err = 0; a0 = 0;
  endtask

  // Stray activity that the current state must ignore.
  task automatic drive_noise(input logic [2:0] st);
    if (!noise_en) return;
    a0            = $urandom;
    ifu_err       = 1'($urandom_range(0, 1));
    idu_is_ebreak = 1'($urandom_range(0, 1));
    if (st != S_FETCH)  ifu_fire = 1'($urandom_range(0, 1));
    if (st != S_DECODE) idu_fire = 1'($urandom_range(0, 1));
    if (st != S_EXEC) begin
      pc_valid = 1'($urandom_range(0, 1));
      next_pc  = $urandom;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    @(negedge clock);
    @(negedge clock);
    chk("rst_state", state_out, S_IDLE);
    chk("rst_pc", ifu_pc, RST_PC);
    chk("rst_ifu_start", ifu_start, 0);
    chk("rst_pc_ready", pc_ready, 0);
    chk("rst_halt", halt, 0);
    chk("rst_cause", halt_cause, 0);
    chk("rst_exit", exit_code, 0);
`ifdef CORE_SEQ_PERF_CNT_EN
    chk("rst_perf_cycle", perf_cycle, 0);
    chk("rst_perf_instret", perf_instret, 0);
    chk("rst_perf_memstall", perf_memstall, 0);
`endif
  endtask

  task automatic run_stage(input logic [2:0] st, input ins_t ins, output logic halted);
    int w;
    logic fire;
    w = (st == S_FETCH) ? ins.fw : (st == S_DECODE) ? ins.dw : ins.ew;
    halted = 1'b0;
    for (int c = 0; c <= w; c++) begin
      fire = (c == w);
      chk("stage_state", state_out, st);
      chk("stage_pc_ready", pc_ready, st == S_EXEC);
      chk("stage_ifu_start", ifu_start, (st == S_FETCH) && (c == 0));
      chk("stage_halt", halt, 0);
      drive_noise(st);
      if (fire) begin
        if (st == S_FETCH) begin
          ifu_fire = 1; ifu_err = ins.ifu_err; halted = ins.ifu_err;
        end else if (st == S_DECODE) begin
          idu_fire = 1; idu_is_ebreak = ins.ebreak;
        end else begin
          pc_valid = 1; next_pc = ins.npc; lsu_err = ins.lsu_err; a0 = ins.a0;
          halted = ins.lsu_err || ins.ebreak;
        end
      end
      @(negedge clock);
      clear_inputs();
      if (fire) break;
      if (c == T - 1) begin
        halted = 1'b1;   // watchdog budget used up
        break;
      end
    end
  endtask

  task automatic check_fetch_entry();
    chk("fetch_ifu_start", ifu_start, 1);
    chk("fetch_state", state_out, S_FETCH);
    if (exp_q.size() != 0) begin
      chk("fetch_pc", ifu_pc, exp_q.pop_front());
    end else begin
      checks++; failures++;
      $display("FAIL fetch_pc: got 0x%0h expected no further fetch", ifu_pc);
    end
  endtask

  task automatic run_prog();
    res_t r;
    logic done;
    r = model_run();
    apply_reset();
    reset = 1'b0;
    @(negedge clock);
    done = 1'b0;
    foreach (prog[i]) begin
      if (!done) begin
        check_fetch_entry();
        run_stage(S_FETCH, prog[i], done);
        if (!done) run_stage(S_DECODE, prog[i], done);
        if (!done) run_stage(S_EXEC, prog[i], done);
        if (!done) begin
          chk("commit_state", state_out, S_COMMIT);
          chk("commit_pc_ready", pc_ready, 0);
          chk("commit_ifu_start", ifu_start, 0);
          chk("commit_pc", ifu_pc, prog[i].npc);
          drive_noise(S_COMMIT);
          @(negedge clock);
          clear_inputs();
        end
      end
    end
    if (!done) begin
      check_fetch_entry();
      chk("run_exit", exit_code, 0);
`ifdef CORE_SEQ_PERF_CNT_EN
      chk("run_perf_cycle", perf_cycle, r.cycles);
      chk("run_perf_instret", perf_instret, r.instret);
      chk("run_perf_memstall", perf_memstall, r.memstall);
`endif
    end else begin
      for (int k = 0; k < 4; k++) begin
        chk("halt_state", state_out, S_HALT);
        chk("halt_flag", halt, 1);
        chk("halt_cause", halt_cause, r.cause);
        chk("halt_exit", exit_code, r.exit_code);
        chk("halt_pc", ifu_pc, r.pc);
        chk("halt_ifu_start", ifu_start, 0);
        chk("halt_pc_ready", pc_ready, 0);
`ifdef CORE_SEQ_PERF_CNT_EN
        chk("halt_perf_cycle", perf_cycle, r.cycles);
        chk("halt_perf_instret", perf_instret, r.instret);
        chk("halt_perf_memstall", perf_memstall, r.memstall);
`endif
        // Everything is ignored once halted.
        ifu_fire = 1; ifu_err = 1'($urandom_range(0, 1)); idu_fire = 1;
        pc_valid = 1; next_pc = $urandom; lsu_err = 1'($urandom_range(0, 1));
        a0 = $urandom;
        @(negedge clock);
        clear_inputs();
      end
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic cyc(input logic f_ifu, f_idu, f_pc, input logic [31:0] npc);
    ifu_fire = f_ifu; idu_fire = f_idu; pc_valid = f_pc; next_pc = npc;
    @(negedge clock);
    clear_inputs();
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[10];

  initial begin
    tbl[0] = '{ins: mk(3, 1, 0, 0, 0, 0, 32'h3000_0004, 0),  exp_halt: 0, exp_cause: 0, exp_pc: 32'h3000_0004, exp_exit: 0};
    tbl[1] = '{ins: mk(0, 0, 1, 0, 1, 0, 32'h3000_0040, 32'h2A), exp_halt: 1, exp_cause: 0, exp_pc: 32'h3000_0000, exp_exit: 32'h2A};
    tbl[2] = '{ins: mk(0, 0, 0, 0, 0, 1, 32'h3000_0040, 0),  exp_halt: 1, exp_cause: 2, exp_pc: 32'h3000_0000, exp_exit: 0};
    tbl[3] = '{ins: mk(1, 0, 0, 1, 0, 0, 32'h3000_0040, 0),  exp_halt: 1, exp_cause: 1, exp_pc: 32'h3000_0000, exp_exit: 0};
    tbl[4] = '{ins: mk(16, 0, 0, 0, 0, 0, 32'h3000_0040, 0), exp_halt: 1, exp_cause: 3, exp_pc: 32'h3000_0000, exp_exit: 0};
    tbl[5] = '{ins: mk(15, 0, 0, 0, 0, 0, 32'h3000_0040, 0), exp_halt: 0, exp_cause: 0, exp_pc: 32'h3000_0040, exp_exit: 0};
    tbl[6] = '{ins: mk(0, 20, 0, 0, 0, 0, 32'h3000_0040, 0), exp_halt: 1, exp_cause: 3, exp_pc: 32'h3000_0000, exp_exit: 0};
    tbl[7] = '{ins: mk(0, 0, 16, 0, 0, 0, 32'h3000_0040, 0), exp_halt: 1, exp_cause: 3, exp_pc: 32'h3000_0000, exp_exit: 0};
    tbl[8] = '{ins: mk(0, 15, 15, 0, 0, 0, 32'h1234_5679, 0), exp_halt: 0, exp_cause: 0, exp_pc: 32'h1234_5679, exp_exit: 0};
    tbl[9] = '{ins: mk(2, 2, 2, 0, 1, 1, 32'h3000_0040, 32'h77), exp_halt: 1, exp_cause: 2, exp_pc: 32'h3000_0000, exp_exit: 0};

    clear_inputs();

    // Table vectors: one instruction from reset each.
    noise_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      prog.delete();
      prog.push_back(tbl[i].ins);
      run_prog();
      chk("tbl_halt", halt, tbl[i].exp_halt);
      if (tbl[i].exp_halt) chk("tbl_cause", halt_cause, tbl[i].exp_cause);
      chk("tbl_pc", ifu_pc, tbl[i].exp_pc);
      chk("tbl_exit", exit_code, tbl[i].exp_exit);
    end

    // Reset in EXEC with a same-cycle commit request: no commit happens.
    apply_reset();
    reset = 1'b0;
    @(negedge clock);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 32'h3000_0100);
    chk("mid_commit_pc", ifu_pc, 32'h3000_0100);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("mid_exec_state", state_out, S_EXEC);
    reset = 1'b1;
    cyc(0, 0, 1, 32'h3000_0200);
    chk("mid_rst_state", state_out, S_IDLE);
    chk("mid_rst_pc", ifu_pc, RST_PC);
    chk("mid_rst_halt", halt, 0);
    chk("mid_rst_pc_ready", pc_ready, 0);

    // Reset out of HALT.
    reset = 1'b0;
    @(negedge clock);
    ifu_err = 1'b1;
    cyc(1, 0, 0, 0);
    chk("halt_err_state", state_out, S_HALT);
    chk("halt_err_cause", halt_cause, 1);
    reset = 1'b1;
    cyc(0, 0, 0, 0);
    chk("halt_rst_state", state_out, S_IDLE);
    chk("halt_rst_halt", halt, 0);
    chk("halt_rst_cause", halt_cause, 0);

    // Ten instructions with two EXEC wait cycles each, ending on ebreak.
    prog.delete();
    for (int i = 0; i < 10; i++)
      prog.push_back(mk(0, 0, 2, 0, i == 9, 0, RST_PC + 32'(4 * (i + 1)), 32'h55));
    run_prog();

    // Random instruction streams with stray handshakes.
    noise_en = 1'b1;
    for (int p = 0; p < 14; p++) begin
      int n;
      n = $urandom_range(2, 8);
      prog.delete();
      for (int i = 0; i < n; i++) begin
        ins_t x;
        x.fw = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
        x.dw = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
        x.ew = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
        x.ifu_err = ($urandom_range(0, 19) == 0);
        x.lsu_err = ($urandom_range(0, 19) == 0);
        x.ebreak  = ($urandom_range(0, 7) == 0) || (i == n - 1 && p[0]);
        x.npc     = $urandom;
        x.a0      = $urandom;
        prog.push_back(x);
      end
      run_prog();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900_000;
    failures++;
    $display("FAIL sim_time_limit: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
